ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
// - Execute stage directly downstream of the ID/EX register; consumes its ex_* outputs.
// - Computes RV32I ALU results, load/store addresses and branch/jump outcomes.
// - Drives the mispredict redirect (b_flag_o, b_target_o) back to PC, IF/ID and ID/EX.
// - Owns the EX/MEM pipeline register feeding the MEM stage.
// PARAMETERS
// - XLEN        32  datapath / address width
// - ALUOP_W     6   width of the aluop code (shared EX_* encoding)
// - REG_ADDR_W  5   register-file address width
// - STALL_W     6   stall vector width; bit order: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
// PORTS
// - clk          in   1           core clock; all state on the rising edge
// - rst_n        in   1           asynchronous, active-low reset
// - rdy          in   1           global ready; low freezes all state
// - stall_state  in   STALL_W     pipeline stall vector
// - ex_aluop     in   ALUOP_W     operation from ID/EX
// - ex_r1        in   XLEN        operand 1 (rs1 value)
// - ex_r2        in   XLEN        operand 2 (rs2 value or immediate)
// - ex_w_addr    in   REG_ADDR_W  destination register
// - ex_w_req     in   1           destination write enable
// - ex_pc        in   XLEN        instruction PC
// - ex_offset    in   XLEN        branch/jump/load/store offset
// - ex_taken     in   1           predicted-taken bit from IF
// - b_flag_o     out  1           mispredict redirect, combinational
// - b_target_o   out  XLEN        correct next PC when b_flag_o=1, else 0
// - mem_aluop    out  ALUOP_W     registered op to MEM
// - mem_w_addr   out  REG_ADDR_W  registered destination
// - mem_w_req    out  1           registered write enable
// - mem_wdata    out  XLEN        registered ALU / link result
// - mem_addr     out  XLEN        registered load/store address (r1+offset)
// - mem_sdata    out  XLEN        registered store data (r2)
// - perf_br_cnt  out  32          resolved branch/jump count (see CONFIGURATION)
// - perf_mis_cnt out  32          mispredict count (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_n=0, async): mem_aluop=EX_NOP; all other mem_* outputs and perf counters = 0.
// - Reset is honoured mid-stall.
// - advance = rdy & ~stall_state[3].
// - Register update on each posedge:
//   - rdy=0 or stall_state[3]=1: hold all registers.
//   - otherwise, if stall_state[2]=1: load a bubble (EX_NOP, zeros, mem_w_req=0).
//   - otherwise: load computed values; mem_w_req = ex_w_req & (ex_w_addr!=0).
// - Latency: one cycle from ex_* inputs to mem_* outputs.
// - Arithmetic:
//   - All ops modulo 2^XLEN.
//   - Shifts use r2[4:0]; SRA/SRAI sign-fill.
//   - SLT signed, SLTU unsigned; LUI passes r2; AUIPC = pc+offset.
// - Branches (BEQ..BGEU): actual = compare(r1,r2); target = actual ? pc+offset : pc+4.
// - JAL: actual taken; target = pc+offset; mem_wdata = pc+4.
// - JALR: always mispredicted; target = (r1+offset) & ~1; mem_wdata = pc+4.
// - b_flag_o = advance & is_ctrl & (actual != ex_taken | is_jalr). Combinational, same cycle.
// - b_flag_o is therefore a single pulse per instruction even across a multi-cycle EX stall.
// - Non-control ops and EX_NOP never raise b_flag_o.
// - Unknown aluop: treated as EX_NOP (bubble written, no redirect).
// CONFIGURATION
// - Macro EX_PERF_CNT_EN defined:
//   - perf_br_cnt += 1 per advancing control op.
//   - perf_mis_cnt += 1 per b_flag_o pulse.
//   - Both frozen when rdy=0; both wrap 0xFFFFFFFF -> 0; both cleared only by reset.
// - Macro undefined: counters not built; perf_br_cnt and perf_mis_cnt tied to 0.
// STRUCTURE
// - Shared definitions package/header holds:
//   - EX_* aluop encodings, ZeroWord, NOPRegAddr.
//   - Bus widths (RegBus, InstAddrBus, AluOpBus, StallBus) and stall bit indices.
// - Sub-module ex_alu (combinational):
//   - operands and aluop in; result, actual_taken, target, is_ctrl, is_jalr out.
// - ex_stage holds the redirect logic, the EX/MEM register and the optional counters.
// TESTING
// - ADD r1=0x7FFFFFFF, r2=1, w_addr=5 -> next edge: mem_wdata=0x80000000, mem_w_req=1.
// - ADD with w_addr=0, w_req=1 -> mem_w_req=0.
// - BEQ r1=r2=3, pc=0x100, offset=0x20, taken=0 -> b_flag_o=1, b_target_o=0x120 same cycle.
// - BNE r1=r2, taken=1 -> b_flag_o=1, b_target_o=pc+4; the correctly predicted case -> b_flag_o=0.
// - JALR r1=0x1003, offset=4, pc=0x40 -> b_flag_o=1, b_target_o=0x1006, mem_wdata=0x44.
// - stall_state=6'b001000 for 3 cycles with pending mispredicted BLT:
//   - mem_* held and b_flag_o=0 during the stall.
//   - one b_flag_o pulse when the stall releases.
//   - stall_state=6'b000100 -> EX_NOP bubble written.
// - EX_PERF_CNT_EN: 4 branches, 2 mispredicted -> perf_br_cnt=4, perf_mis_cnt=2.
// - EX_PERF_CNT_EN: rst_n low mid-run -> counters and mem_* cleared immediately (async).

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: definitions shared by the execute stage and its ALU.
//   - bus widths (RegBus, InstAddrBus, AluOpBus, StallBus, RegAddrBus)
//   - stall vector bit indices (0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb)
//   - EX_* aluop encodings, ZeroWord, NOPRegAddr
//   - EX/MEM register layout and the bubble value loaded into it
package ex_stage_pkg;

  localparam int XLEN       = 32;
  localparam int ALUOP_W    = 6;
  localparam int REG_ADDR_W = 5;
  localparam int STALL_W    = 6;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  typedef logic [XLEN-1:0]       RegBus;
  typedef logic [XLEN-1:0]       InstAddrBus;
  typedef logic [ALUOP_W-1:0]    AluOpBus;
  typedef logic [STALL_W-1:0]    StallBus;
  typedef logic [REG_ADDR_W-1:0] RegAddrBus;

  localparam RegBus     ZeroWord   = '0;
  localparam RegAddrBus NOPRegAddr = '0;

  // Register-immediate forms reuse the register-register codes with the
  // immediate already placed in operand 2 by the decoder.
  typedef enum logic [ALUOP_W-1:0] {
    EX_NOP   = 6'd0,
    EX_ADD   = 6'd1,
    EX_SUB   = 6'd2,
    EX_SLL   = 6'd3,
    EX_SLT   = 6'd4,
    EX_SLTU  = 6'd5,
    EX_XOR   = 6'd6,
    EX_SRL   = 6'd7,
    EX_SRA   = 6'd8,
    EX_OR    = 6'd9,
    EX_AND   = 6'd10,
    EX_LUI   = 6'd11,
    EX_AUIPC = 6'd12,
    EX_JAL   = 6'd13,
    EX_JALR  = 6'd14,
    EX_BEQ   = 6'd15,
    EX_BNE   = 6'd16,
    EX_BLT   = 6'd17,
    EX_BGE   = 6'd18,
    EX_BLTU  = 6'd19,
    EX_BGEU  = 6'd20,
    EX_LB    = 6'd21,
    EX_LH    = 6'd22,
    EX_LW    = 6'd23,
    EX_LBU   = 6'd24,
    EX_LHU   = 6'd25,
    EX_SB    = 6'd26,
    EX_SH    = 6'd27,
    EX_SW    = 6'd28
  } ex_aluop_e;

  typedef struct packed {
    AluOpBus   aluop;
    RegAddrBus w_addr;
    logic      w_req;
    RegBus     wdata;
    RegBus     addr;
    RegBus     sdata;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '{
    aluop:  AluOpBus'(EX_NOP),
    w_addr: NOPRegAddr,
    w_req:  1'b0,
    wdata:  ZeroWord,
    addr:   ZeroWord,
    sdata:  ZeroWord
  };

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational RV32I execute datapath.
// Ports:
//   aluop_i      operation code (EX_* encoding)
//   r1_i, r2_i   operands (r2 is rs2 or immediate)
//   pc_i         instruction PC
//   offset_i     branch/jump/load/store offset
//   result_o     ALU result, or pc+4 link value for JAL/JALR
//   addr_o       r1+offset, the load/store address
//   taken_o      actual branch/jump outcome
//   target_o     correct next PC for a control op
//   is_ctrl_o    op is a branch, JAL or JALR
//   is_jalr_o    op is JALR
//   valid_o      op is a known, non-NOP operation
module ex_alu
  import ex_stage_pkg::*;
(
  input  AluOpBus    aluop_i,
  input  RegBus      r1_i,
  input  RegBus      r2_i,
  input  InstAddrBus pc_i,
  input  RegBus      offset_i,
  output RegBus      result_o,
  output RegBus      addr_o,
  output logic       taken_o,
  output InstAddrBus target_o,
  output logic       is_ctrl_o,
  output logic       is_jalr_o,
  output logic       valid_o
);

  logic [4:0] shamt;
  InstAddrBus pc_plus4;
  InstAddrBus br_target;

  assign shamt     = r2_i[4:0];
  assign pc_plus4  = pc_i + InstAddrBus'(4);
  assign br_target = pc_i + offset_i;
  assign addr_o    = r1_i + offset_i;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // the case leaves one unassigned and no latch is inferred.
    result_o  = ZeroWord;
    taken_o   = 1'b0;
    is_ctrl_o = 1'b0;
    is_jalr_o = 1'b0;
    valid_o   = 1'b1;
    case (aluop_i)
      EX_ADD:   result_o = r1_i + r2_i;
      EX_SUB:   result_o = r1_i - r2_i;
      EX_SLL:   result_o = r1_i << shamt;
      EX_SLT:   result_o = {{(XLEN-1){1'b0}}, ($signed(r1_i) < $signed(r2_i))};
      EX_SLTU:  result_o = {{(XLEN-1){1'b0}}, (r1_i < r2_i)};
      EX_XOR:   result_o = r1_i ^ r2_i;
      EX_SRL:   result_o = r1_i >> shamt;
      EX_SRA:   result_o = $signed(r1_i) >>> shamt;
      EX_OR:    result_o = r1_i | r2_i;
      EX_AND:   result_o = r1_i & r2_i;
      EX_LUI:   result_o = r2_i;
      EX_AUIPC: result_o = br_target;
      EX_JAL: begin
        result_o  = pc_plus4;
        taken_o   = 1'b1;
        is_ctrl_o = 1'b1;
      end
      EX_JALR: begin
        result_o  = pc_plus4;
        taken_o   = 1'b1;
        is_ctrl_o = 1'b1;
        is_jalr_o = 1'b1;
      end
      EX_BEQ:  begin is_ctrl_o = 1'b1; taken_o = (r1_i == r2_i); end
      EX_BNE:  begin is_ctrl_o = 1'b1; taken_o = (r1_i != r2_i); end
      EX_BLT:  begin is_ctrl_o = 1'b1; taken_o = ($signed(r1_i) <  $signed(r2_i)); end
      EX_BGE:  begin is_ctrl_o = 1'b1; taken_o = ($signed(r1_i) >= $signed(r2_i)); end
      EX_BLTU: begin is_ctrl_o = 1'b1; taken_o = (r1_i <  r2_i); end
      EX_BGEU: begin is_ctrl_o = 1'b1; taken_o = (r1_i >= r2_i); end
      // Memory ops only need the address and store data, both handled outside.
      EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU,
      EX_SB, EX_SH, EX_SW: result_o = ZeroWord;
      // EX_NOP and any unused code become a bubble.
      default: valid_o = 1'b0;
    endcase

    // JALR clears bit 0 of the computed address; a not-taken branch falls through.
    if (is_jalr_o) target_o = addr_o & ~InstAddrBus'(1);
    else           target_o = taken_o ? br_target : pc_plus4;
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with the EX/MEM pipeline register.
// Computes ALU results, load/store addresses and branch outcomes, drives the
// combinational mispredict redirect, and registers results towards MEM.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rdy                global ready; low freezes all state
//   stall_state        stall vector (bit 2 id -> bubble, bit 3 ex -> hold)
//   ex_*               operation and operands from the ID/EX register
//   b_flag_o           mispredict redirect (combinational)
//   b_target_o         correct next PC when b_flag_o=1, else 0
//   mem_*              EX/MEM register outputs
//   perf_br_cnt        resolved control-op count
//   perf_mis_cnt       mispredict count
// Optional feature: define EX_PERF_CNT_EN to build the performance counters;
// otherwise both counter outputs are tied to zero.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  StallBus     stall_state,
  input  AluOpBus     ex_aluop,
  input  RegBus       ex_r1,
  input  RegBus       ex_r2,
  input  RegAddrBus   ex_w_addr,
  input  logic        ex_w_req,
  input  InstAddrBus  ex_pc,
  input  RegBus       ex_offset,
  input  logic        ex_taken,
  output logic        b_flag_o,
  output InstAddrBus  b_target_o,
  output AluOpBus     mem_aluop,
  output RegAddrBus   mem_w_addr,
  output logic        mem_w_req,
  output RegBus       mem_wdata,
  output RegBus       mem_addr,
  output RegBus       mem_sdata,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_mis_cnt
);

  RegBus      alu_result;
  RegBus      alu_addr;
  logic       alu_taken;
  InstAddrBus alu_target;
  logic       alu_is_ctrl;
  logic       alu_is_jalr;
  logic       alu_valid;

  ex_alu u_alu (
    .aluop_i   (ex_aluop),
    .r1_i      (ex_r1),
    .r2_i      (ex_r2),
    .pc_i      (ex_pc),
    .offset_i  (ex_offset),
    .result_o  (alu_result),
    .addr_o    (alu_addr),
    .taken_o   (alu_taken),
    .target_o  (alu_target),
    .is_ctrl_o (alu_is_ctrl),
    .is_jalr_o (alu_is_jalr),
    .valid_o   (alu_valid)
  );

  // Only the id and ex stall bits concern this stage.
  logic unused_stall;
  assign unused_stall = ^{stall_state[STALL_WB], stall_state[STALL_MEM],
                          stall_state[STALL_IF], stall_state[STALL_PC]};

  logic advance;
  assign advance = rdy & ~stall_state[STALL_EX];

  // Gating on advance keeps the redirect to one pulse per instruction even
  // when EX is held for several cycles.
  assign b_flag_o   = advance & alu_is_ctrl & ((alu_taken != ex_taken) | alu_is_jalr);
  assign b_target_o = b_flag_o ? alu_target : ZeroWord;

  ex_mem_t mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (advance) begin
      if (stall_state[STALL_ID] || !alu_valid) begin
        mem_d = EX_MEM_BUBBLE;
      end else begin
        mem_d = '{
          aluop:  ex_aluop,
          w_addr: ex_w_addr,
          w_req:  ex_w_req & (ex_w_addr != NOPRegAddr),
          wdata:  alu_result,
          addr:   alu_addr,
          sdata:  ex_r2
        };
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (!rst_n) mem_q <= EX_MEM_BUBBLE;
    else        mem_q <= mem_d;
  end

  assign mem_aluop  = mem_q.aluop;
  assign mem_w_addr = mem_q.w_addr;
  assign mem_w_req  = mem_q.w_req;
  assign mem_wdata  = mem_q.wdata;
  assign mem_addr   = mem_q.addr;
  assign mem_sdata  = mem_q.sdata;

`ifdef EX_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;

  // Both counters wrap naturally; advance already folds in rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (advance && alu_is_ctrl) br_cnt_q  <= br_cnt_q + 32'd1;
      if (b_flag_o)               mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign perf_br_cnt  = br_cnt_q;
  assign perf_mis_cnt = mis_cnt_q;
`else
  assign perf_br_cnt  = 32'd0;
  assign perf_mis_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
// Each step drives one instruction, checks the same-cycle redirect, pushes
// the expected EX/MEM contents to a scoreboard queue, and pops/compares them
// one clock later. Counter expectations follow EX_PERF_CNT_EN.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy = 1'b1;
  StallBus     stall_state = '0;
  AluOpBus     ex_aluop = '0;
  RegBus       ex_r1 = '0;
  RegBus       ex_r2 = '0;
  RegAddrBus   ex_w_addr = '0;
  logic        ex_w_req = 1'b0;
  InstAddrBus  ex_pc = '0;
  RegBus       ex_offset = '0;
  logic        ex_taken = 1'b0;
  logic        b_flag_o;
  InstAddrBus  b_target_o;
  AluOpBus     mem_aluop;
  RegAddrBus   mem_w_addr;
  logic        mem_w_req;
  RegBus       mem_wdata;
  RegBus       mem_addr;
  RegBus       mem_sdata;
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mis_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  ex_mem_t sb_q[$];

  ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .stall_state  (stall_state),
    .ex_aluop     (ex_aluop),
    .ex_r1        (ex_r1),
    .ex_r2        (ex_r2),
    .ex_w_addr    (ex_w_addr),
    .ex_w_req     (ex_w_req),
    .ex_pc        (ex_pc),
    .ex_offset    (ex_offset),
    .ex_taken     (ex_taken),
    .b_flag_o     (b_flag_o),
    .b_target_o   (b_target_o),
    .mem_aluop    (mem_aluop),
    .mem_w_addr   (mem_w_addr),
    .mem_w_req    (mem_w_req),
    .mem_wdata    (mem_wdata),
    .mem_addr     (mem_addr),
    .mem_sdata    (mem_sdata),
    .perf_br_cnt  (perf_br_cnt),
    .perf_mis_cnt (perf_mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic ex_mem_t mk(input AluOpBus op, input RegAddrBus wa, input logic wr,
                                 input RegBus wd, input RegBus ad, input RegBus sd);
    mk = '{aluop: op, w_addr: wa, w_req: wr, wdata: wd, addr: ad, sdata: sd};
  endfunction

  task automatic compare_out(input string tag);
    ex_mem_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".aluop"},  32'(mem_aluop),  32'(e.aluop));
      check({tag, ".w_addr"}, 32'(mem_w_addr), 32'(e.w_addr));
      check({tag, ".w_req"},  32'(mem_w_req),  32'(e.w_req));
      check({tag, ".wdata"},  mem_wdata, e.wdata);
      check({tag, ".addr"},   mem_addr,  e.addr);
      check({tag, ".sdata"},  mem_sdata, e.sdata);
    end
  endtask

  // Drive one instruction, check the redirect before the edge, then check
  // the EX/MEM register one edge later against the scoreboard.
  task automatic step(input string tag, input AluOpBus op, input RegBus r1, input RegBus r2,
                      input RegAddrBus wa, input logic wr, input InstAddrBus pc,
                      input RegBus off, input logic tk, input logic exp_f,
                      input InstAddrBus exp_t, input ex_mem_t exp_m);
    ex_aluop  = op;
    ex_r1     = r1;
    ex_r2     = r2;
    ex_w_addr = wa;
    ex_w_req  = wr;
    ex_pc     = pc;
    ex_offset = off;
    ex_taken  = tk;
    #1;
    check({tag, ".b_flag"},   32'(b_flag_o), 32'(exp_f));
    check({tag, ".b_target"}, b_target_o, exp_t);
    sb_q.push_back(exp_m);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] br, input logic [31:0] mis);
`ifdef EX_PERF_CNT_EN
    check({tag, ".br_cnt"},  perf_br_cnt,  br);
    check({tag, ".mis_cnt"}, perf_mis_cnt, mis);
`else
    check({tag, ".br_cnt"},  perf_br_cnt,  32'(br & 32'd0));
    check({tag, ".mis_cnt"}, perf_mis_cnt, 32'(mis & 32'd0));
`endif
  endtask

  initial begin
    ex_mem_t sw_m;
    ex_mem_t bub;
    bub = mk(EX_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset.aluop",  32'(mem_aluop), 32'(EX_NOP));
    check("reset.w_req",  32'(mem_w_req), 32'h0);
    check("reset.w_addr", 32'(mem_w_addr), 32'h0);
    check("reset.wdata",  mem_wdata, 32'h0);
    check("reset.addr",   mem_addr,  32'h0);
    check("reset.sdata",  mem_sdata, 32'h0);
    check_cnt("reset", 32'd0, 32'd0);
    #10 rst_n = 1'b1;

    // ALU ops.
    step("add_ovf", EX_ADD, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_ADD, 5'd5, 1'b1, 32'h80000000, 32'h7FFFFFFF, 32'h1));
    step("add_x0", EX_ADD, 32'h2, 32'h3, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_ADD, 5'd0, 1'b0, 32'h5, 32'h2, 32'h3));
    step("sub", EX_SUB, 32'h5, 32'h7, 5'd1, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_SUB, 5'd1, 1'b1, 32'hFFFFFFFE, 32'h5, 32'h7));
    step("sra", EX_SRA, 32'h80000010, 32'h24, 5'd2, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_SRA, 5'd2, 1'b1, 32'hF8000001, 32'h80000010, 32'h24));
    step("srl", EX_SRL, 32'h80000010, 32'h24, 5'd2, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_SRL, 5'd2, 1'b1, 32'h08000001, 32'h80000010, 32'h24));
    step("sll", EX_SLL, 32'h1, 32'h21, 5'd3, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_SLL, 5'd3, 1'b1, 32'h2, 32'h1, 32'h21));
    step("slt", EX_SLT, 32'hFFFFFFFF, 32'h1, 5'd4, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_SLT, 5'd4, 1'b1, 32'h1, 32'hFFFFFFFF, 32'h1));
    step("sltu", EX_SLTU, 32'hFFFFFFFF, 32'h1, 5'd4, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_SLTU, 5'd4, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h1));
    step("lui", EX_LUI, 32'h0, 32'h12345000, 5'd6, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, mk(EX_LUI, 5'd6, 1'b1, 32'h12345000, 32'h0, 32'h12345000));
    step("auipc", EX_AUIPC, 32'h0, 32'h0, 5'd7, 1'b1, 32'h200, 32'h1000, 1'b0,
         1'b0, 32'h0, mk(EX_AUIPC, 5'd7, 1'b1, 32'h1200, 32'h1000, 32'h0));

    // Control ops.
    step("beq_mis", EX_BEQ, 32'h3, 32'h3, 5'd0, 1'b0, 32'h100, 32'h20, 1'b0,
         1'b1, 32'h120, mk(EX_BEQ, 5'd0, 1'b0, 32'h0, 32'h23, 32'h3));
    step("bne_mis", EX_BNE, 32'h7, 32'h7, 5'd0, 1'b0, 32'h300, 32'h40, 1'b1,
         1'b1, 32'h304, mk(EX_BNE, 5'd0, 1'b0, 32'h0, 32'h47, 32'h7));
    step("bne_ok", EX_BNE, 32'h1, 32'h2, 5'd0, 1'b0, 32'h300, 32'h40, 1'b1,
         1'b0, 32'h0, mk(EX_BNE, 5'd0, 1'b0, 32'h0, 32'h41, 32'h2));
    step("jalr", EX_JALR, 32'h1003, 32'h0, 5'd1, 1'b1, 32'h40, 32'h4, 1'b0,
         1'b1, 32'h1006, mk(EX_JALR, 5'd1, 1'b1, 32'h44, 32'h1007, 32'h0));
    step("jal", EX_JAL, 32'h0, 32'h0, 5'd1, 1'b1, 32'h80, 32'h100, 1'b1,
         1'b0, 32'h0, mk(EX_JAL, 5'd1, 1'b1, 32'h84, 32'h100, 32'h0));

    // Memory ops.
    step("lw", EX_LW, 32'h1000, 32'h0, 5'd3, 1'b1, 32'h0, 32'h8, 1'b0,
         1'b0, 32'h0, mk(EX_LW, 5'd3, 1'b1, 32'h0, 32'h1008, 32'h0));
    sw_m = mk(EX_SW, 5'd0, 1'b0, 32'h0, 32'h1FFC, 32'hDEADBEEF);
    step("sw", EX_SW, 32'h2000, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 32'hFFFFFFFC, 1'b0,
         1'b0, 32'h0, sw_m);

    // EX stall with a pending mispredicted BLT: hold, no redirect, then one pulse.
    stall_state = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      step("blt_stall", EX_BLT, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 32'h500, 32'h10, 1'b0,
           1'b0, 32'h0, sw_m);
    end
    stall_state = 6'b000000;
    step("blt_release", EX_BLT, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 32'h500, 32'h10, 1'b0,
         1'b1, 32'h510, mk(EX_BLT, 5'd0, 1'b0, 32'h0, 32'h0000000F, 32'h1));

    // ID stall loads a bubble; an unknown code behaves the same way.
    stall_state = 6'b000100;
    step("id_bubble", EX_ADD, 32'h1, 32'h1, 5'd2, 1'b1, 32'h0, 32'h0, 1'b0,
         1'b0, 32'h0, bub);
    stall_state = 6'b000000;
    step("unknown_op", 6'd63, 32'h5, 32'h6, 5'd2, 1'b1, 32'h0, 32'h0, 1'b1,
         1'b0, 32'h0, bub);

    // rdy low freezes everything and suppresses the redirect.
    rdy = 1'b0;
    step("rdy_low", EX_BEQ, 32'h3, 32'h3, 5'd0, 1'b0, 32'h0, 32'h8, 1'b0,
         1'b0, 32'h0, bub);
    rdy = 1'b1;

    // Control ops advanced so far: beq, bne, bne, jalr, jal, blt (once).
    check_cnt("pre_reset", 32'd6, 32'd4);

    // Load a non-bubble value, then reset mid-run between clock edges.
    step("pre_rst_add", EX_ADD, 32'h10, 32'h20, 5'd9, 1'b1, 32'h0, 32'h4, 1'b0,
         1'b0, 32'h0, mk(EX_ADD, 5'd9, 1'b1, 32'h30, 32'h14, 32'h20));
    ex_aluop = EX_NOP;
    rst_n = 1'b0;
    #1;
    check("mid_rst.aluop", 32'(mem_aluop), 32'(EX_NOP));
    check("mid_rst.w_req", 32'(mem_w_req), 32'h0);
    check("mid_rst.wdata", mem_wdata, 32'h0);
    check("mid_rst.addr",  mem_addr,  32'h0);
    check("mid_rst.sdata", mem_sdata, 32'h0);
    check("mid_rst.br_cnt",  perf_br_cnt,  32'h0);
    check("mid_rst.mis_cnt", perf_mis_cnt, 32'h0);
    #1 rst_n = 1'b1;

    // Four branches, two mispredicted.
    step("br4_beq_mis", EX_BEQ, 32'h1, 32'h1, 5'd0, 1'b0, 32'h0, 32'h10, 1'b0,
         1'b1, 32'h10, mk(EX_BEQ, 5'd0, 1'b0, 32'h0, 32'h11, 32'h1));
    step("br4_beq_ok", EX_BEQ, 32'h1, 32'h2, 5'd0, 1'b0, 32'h0, 32'h10, 1'b0,
         1'b0, 32'h0, mk(EX_BEQ, 5'd0, 1'b0, 32'h0, 32'h11, 32'h2));
    step("br4_bge_mis", EX_BGE, 32'h5, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h20, 32'h8, 1'b0,
         1'b1, 32'h28, mk(EX_BGE, 5'd0, 1'b0, 32'h0, 32'hD, 32'hFFFFFFFF));
    step("br4_bgeu_ok", EX_BGEU, 32'h5, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h20, 32'h8, 1'b0,
         1'b0, 32'h0, mk(EX_BGEU, 5'd0, 1'b0, 32'h0, 32'hD, 32'hFFFFFFFF));
    check_cnt("br4", 32'd4, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
